cnn_layer_seq: RTL
==================

# cnn_layer_seq

Parametrised layer sequencer for the CNN accelerator, next generation of the layer controller. Walks one convolution layer as a sequence of output-channel tiles: filter-buffer sync, frame stream, then per-tile partial-sum sync. Adds output backpressure, per-tile psum sync, start-time config latching with error check, and optional stride-2 traversal. Sits between the layer-queue front end and the buffer manager and PE array.

## Interface

- W_SIZE, 12, width/height counter width
- W_CHANNEL, 10, tiled channel counter width

- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- q_width, q_height  in  W_SIZE  input frame dimensions
- q_channel  in  W_CHANNEL  tiled input channels
- q_channel_out  in  W_CHANNEL  tiled output channels
- q_stride  in  1  0: stride 1, 1: stride 2; ignored without macro
- q_start  in  1  start pulse, accepted in IDLE only
- fb_load_done  in  1  filter buffer loaded
- pb_sync_done  in  1  psum buffer synced
- i_data_ready  in  1  PE array accepts current position
- o_fb_load_req, o_pb_sync_req  out  1  single-cycle request pulses
- o_ctrl_csync_run, o_ctrl_data_run, o_ctrl_psync_run  out  1  state decodes
- o_busy  out  1  state != IDLE
- o_layer_done, o_cfg_err  out  1  single-cycle pulses
- o_is_first_row/last_row/first_col/last_col/first_chn/last_chn  out  1 each  position flags
- o_row, o_col  out  W_SIZE;  o_chn, o_chn_out  out  W_CHANNEL  current position

## Operation

- States: IDLE, CSYNC, DATA, PSYNC, DONE.
- IDLE: q_start with all dims nonzero → latch q_* into shadow regs, CSYNC. Any dim zero → stay IDLE, o_cfg_err pulse next cycle.
- CSYNC: fb_load_done → DATA.
- DATA: position advances only when i_data_ready=1. Order: col fastest, then chn, then row. Last position accepted → PSYNC.
- PSYNC: pb_sync_done → DONE if chn_out is last, else chn_out+1, CSYNC.
- DONE: one cycle → IDLE.
- Position counters: col/chn/row reset to 0 on entering DATA. chn_out reset to 0 on layer start.
- Flags are combinational on counters vs latched config. last_col: col+step ≥ width. last_row: row+step ≥ height.
- Handshake inputs outside their state are ignored. q_start while busy is ignored; shadow config frozen until IDLE.
- Widths: compare in W_SIZE+1 bits; no wrap for width = 2^W_SIZE−1.

## Timing

- Reset: state IDLE; all counters 0. All pulses, run and busy outputs 0. first_* flags 1. last_* reflect zeroed shadow config.
- q_start at edge N → CSYNC at N+1, o_fb_load_req high for cycle N+1 only. Same rule for o_pb_sync_req on PSYNC entry.
- fb_load_done sampled in CSYNC → DATA next cycle. fb_load_done in the request cycle itself is valid.
- DATA: position held stable while i_data_ready=0. Accepted beats per tile = ceil(W/s)·C·ceil(H/s).
- o_layer_done high exactly during DONE. o_busy drops the following cycle.
- rstn low mid-layer → IDLE and all zeros at the next edge; pending handshakes dropped.

## Configuration

- CNN_SEQ_STRIDE_EN defined: q_stride honoured. Row/col step 2, start at 0 (positions 0,2,4…).
- Not defined: step fixed at 1, q_stride unconnected internally, no stride shadow register.

## Structure

- Shared package/header: state encodings, default widths, stride step constants, the CNN_SEQ_STRIDE_EN guard.
- One sub-module: cnn_pos_counter, the col/chn/row nested counter. Inputs: advance, clear, step, shadow dims. Outputs: position, flags, frame_last.

## Test plan

- W=4, H=3, C=2, Cout=2, ready tied 1, handshakes returned 1 cycle after request → 24 DATA beats per tile, 2 fb and 2 pb requests, o_layer_done one pulse.
- Same config with ready toggled 1/0 each cycle → position held on ready=0, still 24 accepted beats per tile, order unchanged.
- q_start with q_channel=0 → o_cfg_err pulse, o_busy stays 0, no requests.
- q_start and changed q_width mid-layer → ignored, beat count unchanged.
- CNN_SEQ_STRIDE_EN, W=5, H=5, C=1, stride 2 → cols/rows 0,2,4 only, 9 beats per tile; last_col asserted at col 4.
- rstn low during DATA at row 1 → next cycle IDLE, counters 0. New q_start runs a full layer correctly.

Source files
------------

// File: rtl/cnn_layer_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM states, default widths, traversal steps.
// Build option: CNN_SEQ_STRIDE_EN enables stride-2 row/column traversal.
package cnn_layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSYNC,
        ST_DATA,
        ST_PSYNC,
        ST_DONE
    } seq_state_e;

    localparam int W_SIZE_DEF    = 12;
    localparam int W_CHANNEL_DEF = 10;

    localparam logic [1:0] STEP_1 = 2'd1;
    localparam logic [1:0] STEP_2 = 2'd2;

`ifdef CNN_SEQ_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    function automatic logic [1:0] stride_step(input logic stride);
        return (STRIDE_EN && stride) ? STEP_2 : STEP_1;
    endfunction

endpackage

// File: rtl/cnn_layer_seq_pos_counter.sv
// Nested position counter for one tile: column fastest, then input channel, then row.
// Flags compare against the latched layer dimensions with one guard bit so full-range sizes cannot wrap.
module cnn_pos_counter
    import cnn_layer_seq_pkg::*;
#(
    parameter int W_SIZE    = W_SIZE_DEF,
    parameter int W_CHANNEL = W_CHANNEL_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [1:0]           step,
    input  logic [W_SIZE-1:0]    width,
    input  logic [W_SIZE-1:0]    height,
    input  logic [W_CHANNEL-1:0] channel,
    output logic [W_SIZE-1:0]    row,
    output logic [W_SIZE-1:0]    col,
    output logic [W_CHANNEL-1:0] chn,
    output logic                 first_row,
    output logic                 last_row,
    output logic                 first_col,
    output logic                 last_col,
    output logic                 first_chn,
    output logic                 last_chn,
    output logic                 frame_last
);

    logic [W_SIZE:0] step_ext;

    assign step_ext   = {{(W_SIZE-1){1'b0}}, step};

    assign first_row  = (row == '0);
    assign first_col  = (col == '0);
    assign first_chn  = (chn == '0);
    assign last_row   = ({1'b0, row} + step_ext) >= {1'b0, height};
    assign last_col   = ({1'b0, col} + step_ext) >= {1'b0, width};
    assign last_chn   = ({1'b0, chn} + (W_CHANNEL+1)'(1)) >= {1'b0, channel};
    assign frame_last = last_row && last_col && last_chn;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            row <= '0;
            col <= '0;
            chn <= '0;
        end else if (advance) begin
            if (!last_col) begin
                col <= col + step_ext[W_SIZE-1:0];
            end else begin
                col <= '0;
                if (!last_chn) begin
                    chn <= chn + W_CHANNEL'(1);
                end else begin
                    chn <= '0;
                    row <= last_row ? '0 : row + step_ext[W_SIZE-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// Layer sequencer: per output-channel tile runs filter sync, the frame stream, then psum sync.
// Build option: CNN_SEQ_STRIDE_EN latches q_stride and walks rows/columns in steps of 2.
module cnn_layer_seq
    import cnn_layer_seq_pkg::*;
#(
    parameter int W_SIZE    = W_SIZE_DEF,
    parameter int W_CHANNEL = W_CHANNEL_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic                 q_stride,
    input  logic                 q_start,
    input  logic                 fb_load_done,
    input  logic                 pb_sync_done,
    input  logic                 i_data_ready,
    output logic                 o_fb_load_req,
    output logic                 o_pb_sync_req,
    output logic                 o_ctrl_csync_run,
    output logic                 o_ctrl_data_run,
    output logic                 o_ctrl_psync_run,
    output logic                 o_busy,
    output logic                 o_layer_done,
    output logic                 o_cfg_err,
    output logic                 o_is_first_row,
    output logic                 o_is_last_row,
    output logic                 o_is_first_col,
    output logic                 o_is_last_col,
    output logic                 o_is_first_chn,
    output logic                 o_is_last_chn,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic [W_CHANNEL-1:0] o_chn_out
);

    seq_state_e           state;
    logic [W_SIZE-1:0]    cfg_width, cfg_height;
    logic [W_CHANNEL-1:0] cfg_channel, cfg_channel_out, chn_out;
    logic [1:0]           step;
    logic                 cfg_ok, accept_start, pos_clear, pos_advance, frame_last, last_chn_out;

    assign cfg_ok       = (q_width != '0) && (q_height != '0) && (q_channel != '0) && (q_channel_out != '0);
    assign accept_start = (state == ST_IDLE) && q_start && cfg_ok;
    assign pos_clear    = (state == ST_CSYNC) && fb_load_done;
    assign pos_advance  = (state == ST_DATA) && i_data_ready;
    assign last_chn_out = ({1'b0, chn_out} + (W_CHANNEL+1)'(1)) >= {1'b0, cfg_channel_out};

`ifdef CNN_SEQ_STRIDE_EN
    logic cfg_stride;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_stride <= 1'b0;
        end else if (accept_start) begin
            cfg_stride <= q_stride;
        end
    end

    assign step = stride_step(cfg_stride);
`else
    logic unused_stride;

    assign unused_stride = q_stride;
    assign step          = STEP_1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= ST_IDLE;
            cfg_width       <= '0;
            cfg_height      <= '0;
            cfg_channel     <= '0;
            cfg_channel_out <= '0;
            chn_out         <= '0;
            o_fb_load_req   <= 1'b0;
            o_pb_sync_req   <= 1'b0;
            o_cfg_err       <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; a later non-blocking assignment in the case wins.
            o_fb_load_req <= 1'b0;
            o_pb_sync_req <= 1'b0;
            o_cfg_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_start) begin
                        cfg_width       <= q_width;
                        cfg_height      <= q_height;
                        cfg_channel     <= q_channel;
                        cfg_channel_out <= q_channel_out;
                        chn_out         <= '0;
                        o_fb_load_req   <= 1'b1;
                        state           <= ST_CSYNC;
                    end else if (q_start) begin
                        o_cfg_err <= 1'b1;
                    end
                end
                ST_CSYNC: if (fb_load_done) state <= ST_DATA;
                ST_DATA: begin
                    if (pos_advance && frame_last) begin
                        o_pb_sync_req <= 1'b1;
                        state         <= ST_PSYNC;
                    end
                end
                ST_PSYNC: begin
                    if (pb_sync_done) begin
                        if (last_chn_out) begin
                            state <= ST_DONE;
                        end else begin
                            chn_out       <= chn_out + W_CHANNEL'(1);
                            o_fb_load_req <= 1'b1;
                            state         <= ST_CSYNC;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    cnn_pos_counter #(
        .W_SIZE    (W_SIZE),
        .W_CHANNEL (W_CHANNEL)
    ) u_pos (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (pos_clear),
        .advance    (pos_advance),
        .step       (step),
        .width      (cfg_width),
        .height     (cfg_height),
        .channel    (cfg_channel),
        .row        (o_row),
        .col        (o_col),
        .chn        (o_chn),
        .first_row  (o_is_first_row),
        .last_row   (o_is_last_row),
        .first_col  (o_is_first_col),
        .last_col   (o_is_last_col),
        .first_chn  (o_is_first_chn),
        .last_chn   (o_is_last_chn),
        .frame_last (frame_last)
    );

    assign o_chn_out        = chn_out;
    assign o_ctrl_csync_run = (state == ST_CSYNC);
    assign o_ctrl_data_run  = (state == ST_DATA);
    assign o_ctrl_psync_run = (state == ST_PSYNC);
    assign o_busy           = (state != ST_IDLE);
    assign o_layer_done     = (state == ST_DONE);

endmodule
